// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
//
//   MULT / MULTU : 64-bit product (signed / unsigned), busy for 2 cycles
//                  (MUL then FIX). HI = product[63:32], LO = product[31:0].
//   DIV  / DIVU  : restoring division on operand magnitudes, one quotient bit
//                  per cycle, 32 iterations then FIX, busy for 33 cycles.
//                  LO = quotient, HI = remainder. For the signed form the
//                  quotient is negated when operand signs differ and the
//                  remainder takes the sign of the dividend.
//   Divide by 0  : goes straight to FIX, LO = 0xFFFFFFFF, HI = dividend,
//                  busy for 1 cycle.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   md_start   in   begin an operation (accepted only when idle)
//   md_opcode  in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   md_op_x    in   32  multiplicand / dividend
//   md_op_y    in   32  multiplier / divisor
//   hi_we      in   MTHI strobe (idle, no start)
//   lo_we      in   MTLO strobe (idle, no start)
//   md_wdata   in   32  MTHI/MTLO data
//   md_busy    out  operation in flight (state != IDLE)
//   md_done    out  one-cycle pulse, first cycle the new HI/LO are visible
//   hi, lo     out  32  architectural HI/LO registers
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              md_start,
  input  logic [1:0]        md_opcode,
  input  logic [DATA_W-1:0] md_op_x,
  input  logic [DATA_W-1:0] md_op_y,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] md_wdata,
  output logic              md_busy,
  output logic              md_done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Two's-complement negate when requested (wraps, so -0x80000000 stays put).
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic              neg);
    return neg ? -v : v;
  endfunction

  // Magnitude of an operand, treating it as signed only for signed opcodes.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
    return neg_if(v, is_signed & v[DATA_W-1]);
  endfunction

  // Widen to 2*DATA_W; the low 2*DATA_W bits of the product of two
  // sign-extended operands are the exact signed product.
  function automatic logic signed [2*DATA_W-1:0] widen(input logic [DATA_W-1:0] v,
                                                       input logic              is_signed);
    return {{DATA_W{is_signed & v[DATA_W-1]}}, v};
  endfunction

  // Opcode decode for the request presented this cycle.
  logic req_div;
  logic req_signed;
  logic req_div_zero;

  assign req_div      = md_opcode[1];
  assign req_signed   = ~md_opcode[0];
  assign req_div_zero = (md_op_y == '0);

  // ---- stage p0: operands and division state captured at start ------------
  logic [1:0]        opcode_p0;
  logic [DATA_W-1:0] x_p0;
  logic [DATA_W-1:0] y_p0;
  logic              div_zero_p0;
  logic              neg_q_p0;
  logic              neg_r_p0;
  logic [DATA_W-1:0] quo_p0;
  logic [DATA_W-1:0] rem_p0;
  logic [DATA_W-1:0] dvsr_p0;

  // ---- stage p1: registered product ---------------------------------------
  logic signed [2*DATA_W-1:0] product_p1;

  logic [CNT_W-1:0]  cnt;
  logic              p0_signed;

  assign p0_signed = ~opcode_p0[0];

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. The remainder is always
  // below the divisor, so one extra bit is enough to hold the shifted value
  // and the sign of the trial subtraction.
  logic [DATA_W:0] rem_shift;
  logic [DATA_W:0] rem_trial;
  logic            trial_ok;

  assign rem_shift = {rem_p0, quo_p0[DATA_W-1]};
  assign rem_trial = rem_shift - {1'b0, dvsr_p0};
  assign trial_ok  = ~rem_trial[DATA_W];

  // Datapath registers carry no reset; state gates every use of them.
  always_ff @(posedge clk) begin
    if (state == IDLE && md_start) begin
      opcode_p0   <= md_opcode;
      x_p0        <= md_op_x;
      y_p0        <= md_op_y;
      div_zero_p0 <= req_div_zero;
      neg_q_p0    <= req_signed & (md_op_x[DATA_W-1] ^ md_op_y[DATA_W-1]);
      neg_r_p0    <= req_signed & md_op_x[DATA_W-1];
      quo_p0      <= magnitude(md_op_x, req_signed);
      dvsr_p0     <= magnitude(md_op_y, req_signed);
      rem_p0      <= '0;
    end else if (state == MUL) begin
      product_p1  <= widen(x_p0, p0_signed) * widen(y_p0, p0_signed);
    end else if (state == DIV) begin
      if (trial_ok) begin
        rem_p0 <= rem_trial[DATA_W-1:0];
        quo_p0 <= {quo_p0[DATA_W-2:0], 1'b1};
      end else begin
        rem_p0 <= rem_shift[DATA_W-1:0];
        quo_p0 <= {quo_p0[DATA_W-2:0], 1'b0};
      end
    end
  end

  // ---- FIX: sign correction and final HI/LO selection ---------------------
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;

  always_comb begin
    res_hi = product_p1[2*DATA_W-1:DATA_W];
    res_lo = product_p1[DATA_W-1:0];
    if (opcode_p0[1]) begin
      if (div_zero_p0) begin
        res_hi = x_p0;
        res_lo = '1;
      end else begin
        res_hi = neg_if(rem_p0, neg_r_p0);
        res_lo = neg_if(quo_p0, neg_q_p0);
      end
    end
  end

  // FSM next state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (md_start) begin
          if (!req_div)         state_next = MUL;
          else if (req_div_zero) state_next = FIX;
          else                  state_next = DIV;
        end
      end
      MUL:     state_next = FIX;
      DIV:     if (cnt == CNT_LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state, iteration counter and the architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_next;
      md_done <= (state == FIX);
      if (state == DIV) cnt <= cnt + CNT_W'(1);
      else              cnt <= '0;

      if (state == FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE && !md_start) begin
        // A start in the same cycle takes priority and drops the write.
        if (hi_we) hi <= md_wdata;
        if (lo_we) lo <= md_wdata;
      end
    end
  end

  assign md_busy = (state != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic [1:0]  md_opcode;
  logic [31:0] md_op_x;
  logic [31:0] md_op_y;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] md_wdata;
  logic        md_busy;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .md_start  (md_start),
    .md_opcode (md_opcode),
    .md_op_x   (md_op_x),
    .md_op_y   (md_op_y),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .md_wdata  (md_wdata),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .hi        (hi),
    .lo        (lo)
  );

  // Issue one operation, scramble the operand inputs after the start edge,
  // count busy cycles (bounded), note md_done on the first idle cycle and
  // count any further done pulses in the cycle after that.
  task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        output int busy_n, output logic done_first, output int extra_done);
    @(negedge clk);
    md_opcode = op; md_op_x = x; md_op_y = y; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op_x = ~x; md_op_y = 32'h3;
    busy_n = 0; extra_done = 0;
    while (md_busy && busy_n < 100) begin
      busy_n++;
      if (md_done) extra_done++;
      @(negedge clk);
    end
    done_first = md_done;
    @(negedge clk);
    if (md_done) extra_done++;
  endtask

  task automatic test_reset();
    rst = 1'b1; md_start = 1'b0; md_opcode = 2'b00; md_op_x = '0; md_op_y = '0;
    hi_we = 1'b0; lo_we = 1'b0; md_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", md_busy); end
    checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", md_done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_mult();
    int b; logic d; int e;
    run_op(OP_MULT, 32'hFFFFFFFF, 32'd5, b, d, e);
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFB) begin errors++; $display("FAIL mult_lo: got %h expected fffffffb", lo); end
    checks++; if (b !== 2) begin errors++; $display("FAIL mult_busy: got %0d cycles expected 2", b); end
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL mult_done: got %b expected 1", d); end
    checks++; if (e !== 0) begin errors++; $display("FAIL mult_done_width: got %0d stray pulses expected 0", e); end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd5, b, d, e);
    checks++; if (hi !== 32'h00000004) begin errors++; $display("FAIL multu_hi: got %h expected 00000004", hi); end
    checks++; if (lo !== 32'hFFFFFFFB) begin errors++; $display("FAIL multu_lo: got %h expected fffffffb", lo); end
    checks++; if (b !== 2) begin errors++; $display("FAIL multu_busy: got %0d cycles expected 2", b); end
    run_op(OP_MULT, 32'h00001000, 32'hFFFFFFFE, b, d, e);
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFE000) begin errors++; $display("FAIL mult_neg: got %h%h expected ffffffffffffe000", hi, lo); end
  endtask

  task automatic test_div();
    int b; logic d; int e;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, b, d, e);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    checks++; if (b !== 33) begin errors++; $display("FAIL div_busy: got %0d cycles expected 33", b); end
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL div_done: got %b expected 1", d); end
    checks++; if (e !== 0) begin errors++; $display("FAIL div_done_width: got %0d stray pulses expected 0", e); end
    run_op(OP_DIVU, 32'd100, 32'd7, b, d, e);
    checks++; if (lo !== 32'h0000000E) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
    checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
    checks++; if (b !== 33) begin errors++; $display("FAIL divu_busy: got %0d cycles expected 33", b); end
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, b, d, e);
    checks++; if ({hi, lo} !== {32'h00000001, 32'hFFFFFFFD}) begin errors++; $display("FAIL div_pos_neg: got hi=%h lo=%h expected hi=00000001 lo=fffffffd", hi, lo); end
    run_op(OP_DIVU, 32'hFFFFFFF9, 32'd2, b, d, e);
    checks++; if ({hi, lo} !== {32'h00000001, 32'h7FFFFFFC}) begin errors++; $display("FAIL divu_big: got hi=%h lo=%h expected hi=00000001 lo=7ffffffc", hi, lo); end
  endtask

  task automatic test_div_overflow();
    int b; logic d; int e;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, b, d, e);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo: got %h expected 80000000", lo); end
    checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL divovf_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_div_by_zero();
    int b; logic d; int e;
    run_op(OP_DIVU, 32'h00001234, 32'h0, b, d, e);
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL divz_hi: got %h expected 00001234", hi); end
    checks++; if (b !== 1) begin errors++; $display("FAIL divz_busy: got %0d cycles expected 1", b); end
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL divz_done: got %b expected 1", d); end
    run_op(OP_DIV, 32'hFFFFFF00, 32'h0, b, d, e);
    checks++; if ({hi, lo} !== {32'hFFFFFF00, 32'hFFFFFFFF}) begin errors++; $display("FAIL divz_signed: got hi=%h lo=%h expected hi=ffffff00 lo=ffffffff", hi, lo); end
  endtask

  task automatic test_ignore_while_busy();
    int b;
    @(negedge clk);
    md_opcode = OP_DIVU; md_op_x = 32'd1000; md_op_y = 32'd7; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    b = 0;
    while (md_busy && b < 100) begin
      b++;
      if (b == 5) begin
        md_start = 1'b1; md_opcode = OP_MULT; md_op_x = 32'd2; md_op_y = 32'd3;
        hi_we = 1'b1; md_wdata = 32'hDEADBEEF;
      end else begin
        md_start = 1'b0; hi_we = 1'b0;
      end
      @(negedge clk);
    end
    md_start = 1'b0; hi_we = 1'b0;
    checks++; if (b !== 33) begin errors++; $display("FAIL busy_ignore_len: got %0d cycles expected 33", b); end
    checks++; if (md_done !== 1'b1) begin errors++; $display("FAIL busy_ignore_done: got %b expected 1", md_done); end
    checks++; if (lo !== 32'h0000008E) begin errors++; $display("FAIL busy_ignore_lo: got %h expected 0000008e", lo); end
    checks++; if (hi !== 32'h00000006) begin errors++; $display("FAIL busy_ignore_hi: got %h expected 00000006", hi); end
    repeat (2) @(negedge clk);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL busy_no_queue: got busy %b expected 0", md_busy); end
    checks++; if (hi !== 32'h00000006) begin errors++; $display("FAIL busy_hold_hi: got %h expected 00000006", hi); end
  endtask

  task automatic test_reset_mid_op();
    int b; int dn;
    @(negedge clk);
    md_opcode = OP_DIVU; md_op_x = 32'd1000; md_op_y = 32'd7; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    b = 0;
    while (md_busy && b < 100) begin
      b++;
      rst = (b == 10);
      @(negedge clk);
    end
    rst = 1'b0;
    checks++; if (b !== 10) begin errors++; $display("FAIL rstmid_len: got %0d busy cycles expected 10", b); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h expected 00000000", lo); end
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_done) dn++;
      @(negedge clk);
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL rstmid_done: got %0d pulses expected 0", dn); end
    checks++; if ({hi, lo, md_busy} !== 65'h0) begin errors++; $display("FAIL rstmid_after: got hi=%h lo=%h busy=%b expected zeros", hi, lo, md_busy); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    hi_we = 1'b1; md_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    checks++; if (hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL mthi: got %h expected a5a5a5a5", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mthi_lo_hold: got %h expected 00000000", lo); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", md_busy); end
    lo_we = 1'b1; md_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    lo_we = 1'b0;
    checks++; if (lo !== 32'h5A5A5A5A) begin errors++; $display("FAIL mtlo: got %h expected 5a5a5a5a", lo); end
    checks++; if (hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL mtlo_hi_hold: got %h expected a5a5a5a5", hi); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b expected 0", md_busy); end
  endtask

  task automatic test_start_wins();
    int b;
    @(negedge clk);
    md_opcode = OP_MULTU; md_op_x = 32'd3; md_op_y = 32'd4; md_start = 1'b1;
    lo_we = 1'b1; md_wdata = 32'h12345678;
    @(negedge clk);
    md_start = 1'b0; lo_we = 1'b0;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL startwin_busy: got %b expected 1", md_busy); end
    checks++; if (lo !== 32'h5A5A5A5A) begin errors++; $display("FAIL startwin_nowrite: got %h expected 5a5a5a5a", lo); end
    b = 0;
    while (md_busy && b < 100) begin
      b++;
      @(negedge clk);
    end
    checks++; if (b !== 2) begin errors++; $display("FAIL startwin_len: got %0d cycles expected 2", b); end
    checks++; if (lo !== 32'h0000000C) begin errors++; $display("FAIL startwin_lo: got %h expected 0000000c", lo); end
    checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL startwin_hi: got %h expected 00000000", hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_overflow();
    test_div_by_zero();
    test_ignore_while_busy();
    test_reset_mid_op();
    test_mthi_mtlo();
    test_start_wins();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
